input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce.sv | 78 +++++++
 tb/tb_input_debounce.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// Per-channel input debouncer: 2-flop synchronizer, saturating stability counter,
// registered level output plus one-cycle rise/fall pulses and a combined event flag.
module input_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk_100,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_event
);

    localparam int unsigned CntW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q, any_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    // A channel's counter only runs while the synchronized input disagrees with
    // the debounced level; any agreement restarts the whole window.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
        any_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= din;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign q         = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign any_event = any_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed self-checking bench for input_debounce with a 4-cycle debounce window.
module tb_input_debounce;

    localparam int unsigned Width = 8;
    localparam int unsigned Cycles = 4;

    logic             clk_100 = 1'b0;
    logic             reset;
    logic [Width-1:0] din;
    logic [Width-1:0] q, rise, fall;
    logic             any_event;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Event history collected by step_n, cleared by the caller between tests.
    logic [Width-1:0] rise_acc, fall_acc, q_seen_change;
    logic             any_acc, both_acc;

    input_debounce #(
        .WIDTH          (Width),
        .DEBOUNCE_CYCLES(Cycles)
    ) dut (
        .clk_100  (clk_100),
        .reset    (reset),
        .din      (din),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .any_event(any_event)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_acc();
        rise_acc      = '0;
        fall_acc      = '0;
        q_seen_change = '0;
        any_acc       = 1'b0;
        both_acc      = 1'b0;
    endtask

    // Advance n clock edges, sampling outputs 1 time unit after each edge.
    task automatic step_n(input int n);
        logic [Width-1:0] q_prev;
        for (int k = 0; k < n; k++) begin
            q_prev = q;
            @(posedge clk_100);
            #1;
            rise_acc      |= rise;
            fall_acc      |= fall;
            any_acc       |= any_event;
            both_acc      |= |(rise & fall);
            q_seen_change |= q ^ q_prev;
        end
    endtask

    initial begin
        reset = 1'b1;
        din   = '0;
        step_n(3);
        check_eq("reset_q", q, 0);
        check_eq("reset_rise", rise, 0);
        check_eq("reset_fall", fall, 0);
        check_eq("reset_any", any_event, 0);
        reset = 1'b0;
        step_n(2);

        // Clean 0->1 on channel 0: edge 0 is the first step after the change.
        din[0] = 1'b1;
        clear_acc();
        step_n(5);
        check_eq("clean_q_early", q, 8'h00);
        check_eq("clean_no_early_evt", {rise_acc, any_acc}, 0);
        step_n(1);
        check_eq("clean_q_edge5", q, 8'h01);
        check_eq("clean_rise_edge5", rise, 8'h01);
        check_eq("clean_any_edge5", any_event, 1);
        check_eq("clean_fall_edge5", fall, 8'h00);
        step_n(1);
        check_eq("clean_rise_edge6", rise, 8'h00);
        check_eq("clean_any_edge6", any_event, 0);
        check_eq("clean_q_edge6", q, 8'h01);

        // Three-cycle glitch on channel 1 is one short of the window.
        clear_acc();
        din[1] = 1'b1;
        step_n(3);
        din[1] = 1'b0;
        step_n(10);
        check_eq("glitch_q", q, 8'h01);
        check_eq("glitch_events", {rise_acc, fall_acc, 7'b0, any_acc}, 0);

        // Bounce 1,0,1,1,0 on channel 2 then steady 1.
        begin
            logic [4:0] pat;
            pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
            clear_acc();
            for (int k = 0; k < 5; k++) begin
                din[2] = pat[k];
                step_n(1);
            end
        end
        din[2] = 1'b1;
        step_n(5);
        check_eq("bounce_no_early_rise", rise_acc, 0);
        check_eq("bounce_q_early", q, 8'h01);
        step_n(1);
        check_eq("bounce_q_edge5", q, 8'h05);
        check_eq("bounce_rise_edge5", rise, 8'h04);
        step_n(1);
        check_eq("bounce_rise_edge6", rise, 8'h00);

        // Bring channel 7 high, then drop channels 0 and 7 together.
        din[7] = 1'b1;
        step_n(8);
        check_eq("ch7_high_q", q, 8'h85);
        clear_acc();
        din[0] = 1'b0;
        din[7] = 1'b0;
        step_n(5);
        check_eq("dual_no_early_evt", {fall_acc, 7'b0, any_acc}, 0);
        step_n(1);
        check_eq("dual_fall_edge5", fall, 8'h81);
        check_eq("dual_any_edge5", any_event, 1);
        check_eq("dual_rise_edge5", rise, 8'h00);
        check_eq("dual_q_edge5", q, 8'h04);
        step_n(1);
        check_eq("dual_fall_edge6", fall, 8'h00);
        check_eq("dual_any_edge6", any_event, 0);

        // Channel 3 counter reaches 2 (after edge 3), then reset at edge 4.
        din[3] = 1'b1;
        step_n(4);
        check_eq("midcount_q", q, 8'h04);
        reset = 1'b1;
        step_n(1);
        check_eq("midreset_q", q, 8'h00);
        check_eq("midreset_pulses", {rise, fall, 7'b0, any_event}, 0);
        reset = 1'b0;
        clear_acc();
        step_n(1);
        check_eq("post_reset_pulses", {rise, fall, 7'b0, any_event}, 0);
        step_n(4);
        check_eq("post_reset_no_early", {rise_acc, 7'b0, any_acc}, 0);
        step_n(1);
        check_eq("post_reset_rise_edge5", rise, 8'h0C);
        check_eq("post_reset_q_edge5", q, 8'h0C);
        step_n(1);
        check_eq("post_reset_rise_edge6", rise, 8'h00);

        // Long steady period: no activity allowed.
        din = 8'hFF;
        step_n(10);
        check_eq("steady_settled_q", q, 8'hFF);
        clear_acc();
        step_n(1000);
        check_eq("steady_q", q, 8'hFF);
        check_eq("steady_q_changes", q_seen_change, 0);
        check_eq("steady_events", {rise_acc, fall_acc, 7'b0, any_acc}, 0);
        check_eq("never_rise_and_fall", both_acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
